shift_reg_engine: RTL and testbench
===================================

// Module: shift_reg_engine
// PURPOSE
//  Parametrised, multi-cycle shift/rotate engine; successor to the 4-bit load/shift/rotate register.
//  Accepts one command at a time over a valid/ready handshake: load, clear, logical/arithmetic shift, rotate.
//  Shift distance is per-command; the engine moves up to STEP positions per clock and pulses done when finished.
//  Sits in the datapath as a serialiser/aligner; ser_in/ser_out allow chaining of engines.
// PARAMETERS
//  WIDTH   8   register width in bits (>=2)
//  STEP    1   max bit positions moved per clock (1..WIDTH)
//  AMT_W   $clog2(WIDTH+1)   derived localparam: width of cmd_amt
// PORTS
//  clk        in   1       single clock, rising edge
//  rst        in   1       asynchronous, active-low reset (asserted at 0)
//  cmd_valid  in   1       command present
//  cmd_ready  out  1       engine can accept (high only in IDLE)
//  cmd_op     in   3       operation, encoding below
//  cmd_amt    in   AMT_W   shift/rotate distance
//  load_data  in   WIDTH   value for OP_LOAD
//  ser_in     in   1       fill bit for logical shifts; sampled at accept
//  q          out  WIDTH   register contents
//  ser_out    out  1       last bit to leave/cross the register end
//  busy       out  1       high in RUN
//  done       out  1       one-cycle pulse on command completion
// BEHAVIOUR
//  Reset (rst=0, any time incl. mid-command): q=0, ser_out=0, done=0, busy=0, state=IDLE, remaining count cleared.
//  cmd_ready is 1 in IDLE, including while rst is deasserted and idle.
//  Ops: 000 LOAD q<=load_data | 001 SHL (q<<n, fill ser_in) | 010 SHR (q>>n, fill ser_in)
//       011 ASR (q>>n, fill q[WIDTH-1]) | 100 ROL | 101 ROR | 110 NOP | 111 CLEAR q<=0.
//  Accept = cmd_valid & cmd_ready at a rising edge; op, amt, ser_in latched at that edge.
//  Amount normalisation at accept: shifts clamp amt>WIDTH to WIDTH; rotates use amt mod WIDTH.
//  FSM IDLE/RUN:
//   IDLE, accept LOAD/CLEAR/NOP, or shift/rotate with normalised amt=0: q updated (if applicable) on
//     the accept edge; done=1 next cycle; stay IDLE (back-to-back accepts allowed, one per clock).
//   IDLE, accept shift/rotate with amt>0: rem<=amt, -> RUN; q unchanged on the accept edge.
//   RUN: each edge applies k=min(STEP,rem) positions, rem<=rem-k; when rem reaches 0: -> IDLE, done=1 next cycle.
//  Latency: shift/rotate of amt>0 completes ceil(amt/STEP) edges after the accept edge; cmd_ready rises together with done.
//  Intermediate q is visible during RUN (each step's partial result).
//  ser_out: updated on every step that moves bits: SHL -> last bit shifted out of MSB; SHR/ASR -> out of LSB;
//   ROL -> bit moved MSB->LSB; ROR -> LSB->MSB. Holds value otherwise; LOAD/CLEAR/NOP leave it unchanged.
//  ASR fill uses the current MSB at each step (sign preserved across steps).
//  cmd_valid while busy: ignored, not queued; inputs other than during accept are don't-care.
//  done never asserts without a preceding accept; exactly one done per accepted command.
// STRUCTURE
//  Package shift_reg_pkg: op enum (OP_LOAD..OP_CLEAR, 3 bits), state enum (ST_IDLE, ST_RUN).
//  Sub-module shift_reg_step: combinational; inputs q, op, k (0..STEP), fill; outputs next q and ser_out bit.
//  Top holds FSM, rem counter, latched op/fill, q and ser_out registers.
// TESTING
//  (WIDTH=8, STEP=1 unless noted)
//  1 Reset: drive rst=0 mid-RUN of SHL amt=6 -> q=0x00, busy=0, done=0 immediately; cmd_ready=1 after release.
//  2 LOAD 0xA5 then SHL amt=3 ser_in=1 -> done 3 edges after accept, q=0x2F, ser_out=1.
//  3 LOAD 0x96, ASR amt=2 -> q=0xE5, ser_out=1; SHR amt=9 ser_in=0 -> clamped, q=0x00 after 8 edges.
//  4 STEP=3: LOAD 0x81, ROL amt=7 -> q=0xC0 after 3 edges (3,3,1), done pulse single cycle, ser_out=0.
//  5 ROR amt=8 (mod -> 0) on q=0x3C -> q unchanged, done next cycle, no RUN entry.
//  6 Back-to-back: LOAD 0x01, NOP, CLEAR on consecutive edges with cmd_valid held -> three done pulses, q=0x00;
//    cmd_valid during RUN ignored (q and done unaffected).

Source files
------------

// File: rtl/shift_reg_pkg.sv
// shift_reg_pkg: shared op and state encodings for the shift/rotate engine
package shift_reg_pkg;
    typedef enum logic [2:0] {
        OP_LOAD, OP_SHL, OP_SHR, OP_ASR, OP_ROL, OP_ROR, OP_NOP, OP_CLEAR
    } op_t;
    typedef enum logic {ST_IDLE, ST_RUN} state_t;
endpackage

// File: rtl/shift_reg_step.sv
// shift_reg_step: combinational move of q by k single-bit positions (k <= STEP)
//   q/op/k/fill in -> nq (moved value), so (last bit to leave or cross an end; 0 when k=0)
module shift_reg_step
    import shift_reg_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int STEP = 1,
    localparam int AMT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] q,
    input  op_t              op,
    input  logic [AMT_W-1:0] k,
    input  logic             fill,
    output logic [WIDTH-1:0] nq,
    output logic             so
);
    logic msb, in_bit;
    always_comb begin
        nq = q;
        so = 1'b0;
        in_bit = 1'b0;
        msb = op == OP_SHL || op == OP_ROL;
        // unrolled chain of one-bit moves; ASR re-reads the MSB each step to keep the sign
        for (int i = 0; i < STEP; i++) begin
            if (i < int'(k)) begin
                in_bit = (op == OP_SHL || op == OP_SHR) ? fill :
                         (op == OP_ASR || op == OP_ROL) ? nq[WIDTH-1] : nq[0];
                so = msb ? nq[WIDTH-1] : nq[0];
                nq = msb ? {nq[WIDTH-2:0], in_bit} : {in_bit, nq[WIDTH-1:1]};
            end
        end
    end
endmodule

// File: rtl/shift_reg_engine.sv
// shift_reg_engine: multi-cycle load/shift/rotate register with valid/ready command port
//   clk, rst (async, active-low) | cmd_valid/cmd_ready handshake, cmd_op, cmd_amt, load_data, ser_in
//   q register contents, ser_out last bit moved out/around, busy while running, done one-cycle pulse
module shift_reg_engine
    import shift_reg_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int STEP = 1,
    localparam int AMT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [AMT_W-1:0] cmd_amt,
    input  logic [WIDTH-1:0] load_data,
    input  logic             ser_in,
    output logic [WIDTH-1:0] q,
    output logic             ser_out,
    output logic             busy,
    output logic             done
);
    localparam logic [AMT_W-1:0] W_AMT = AMT_W'(WIDTH);
    localparam logic [AMT_W-1:0] S_AMT = AMT_W'(STEP);
    state_t           state;
    op_t              op, op_r;
    logic             fill_r, step_so;
    logic [AMT_W-1:0] rem, namt, k;
    logic [WIDTH-1:0] step_q;
    assign op = op_t'(cmd_op);
    assign cmd_ready = state == ST_IDLE;
    assign busy = state == ST_RUN;
    assign k = rem < S_AMT ? rem : S_AMT;
    // shifts saturate at a full-width flush; rotates wrap modulo WIDTH
    always_comb
        namt = (op == OP_SHL || op == OP_SHR || op == OP_ASR) ? (cmd_amt > W_AMT ? W_AMT : cmd_amt) :
               (op == OP_ROL || op == OP_ROR) ? cmd_amt % W_AMT : '0;
    shift_reg_step #(.WIDTH(WIDTH), .STEP(STEP)) u_step (
        .q(q), .op(op_r), .k(k), .fill(fill_r), .nq(step_q), .so(step_so)
    );
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            q <= '0;
            ser_out <= 1'b0;
            done <= 1'b0;
            rem <= '0;
            op_r <= OP_NOP;
            fill_r <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == ST_IDLE) begin
                if (cmd_valid) begin
                    op_r <= op;
                    fill_r <= ser_in;
                    if (namt != '0) begin
                        rem <= namt;
                        state <= ST_RUN;
                    end else begin
                        done <= 1'b1;
                        q <= op == OP_LOAD ? load_data : op == OP_CLEAR ? '0 : q;
                    end
                end
            end else begin
                q <= step_q;
                ser_out <= step_so;
                rem <= rem - k;
                if (rem == k) begin
                    state <= ST_IDLE;
                    done <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_shift_reg_engine.sv
// tb_shift_reg_engine: two engines (STEP=1, STEP=3) on shared inputs against an arithmetic model
module tb_shift_reg_engine;
    localparam int S0 = 1, S1 = 3;
    logic       clk = 0, rst = 0, cmd_valid = 0, ser_in = 0;
    logic [2:0] cmd_op = 0;
    logic [3:0] cmd_amt = 0;
    logic [7:0] load_data = 0;
    logic [7:0] dq[2];
    logic       dso[2], dbusy[2], ddone[2], drdy[2];
    int tests = 0, fails = 0;
    int mq[2] = '{0, 0}, mso[2] = '{0, 0}, mdone[2] = '{0, 0}, mleft[2] = '{0, 0};
    int mop[2] = '{0, 0}, mfill[2] = '{0, 0};
    int l0, l1, nd;

    always #5 clk = ~clk;

    shift_reg_engine #(.WIDTH(8), .STEP(S0)) u0 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(drdy[0]), .cmd_op(cmd_op),
        .cmd_amt(cmd_amt), .load_data(load_data), .ser_in(ser_in), .q(dq[0]), .ser_out(dso[0]),
        .busy(dbusy[0]), .done(ddone[0])
    );
    shift_reg_engine #(.WIDTH(8), .STEP(S1)) u1 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(drdy[1]), .cmd_op(cmd_op),
        .cmd_amt(cmd_amt), .load_data(load_data), .ser_in(ser_in), .q(dq[1]), .ser_out(dso[1]),
        .busy(dbusy[1]), .done(ddone[1])
    );

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int norm(input int o, input int a);
        if (o >= 1 && o <= 3) return a > 8 ? 8 : a;
        if (o == 4 || o == 5) return a % 8;
        return 0;
    endfunction

    // one-position move on an 8-bit value: returns ser bit * 256 + new value
    function automatic int step1(input int o, input int v, input int f);
        int nv, so;
        so = (o == 1 || o == 4) ? v / 128 : v % 2;
        case (o)
            1: nv = (v * 2) % 256 + f;
            2: nv = v / 2 + f * 128;
            3: nv = v / 2 + (v / 128) * 128;
            4: nv = (v * 2) % 256 + v / 128;
            default: nv = v / 2 + (v % 2) * 128;
        endcase
        return so * 256 + nv;
    endfunction

    initial forever begin
        int n, k, r;
        @(posedge clk or negedge rst);
        for (int d = 0; d < 2; d++) begin
            if (!rst) begin
                mq[d] = 0; mso[d] = 0; mdone[d] = 0; mleft[d] = 0;
            end else begin
                mdone[d] = 0;
                if (mleft[d] == 0) begin
                    if (cmd_valid) begin
                        n = norm(int'(cmd_op), int'(cmd_amt));
                        mop[d] = int'(cmd_op);
                        mfill[d] = int'(ser_in);
                        if (n == 0) begin
                            mdone[d] = 1;
                            if (cmd_op == 0) mq[d] = int'(load_data);
                            else if (cmd_op == 7) mq[d] = 0;
                        end else mleft[d] = n;
                    end
                end else begin
                    k = mleft[d] < (d == 0 ? S0 : S1) ? mleft[d] : (d == 0 ? S0 : S1);
                    for (int j = 0; j < k; j++) begin
                        r = step1(mop[d], mq[d], mfill[d]);
                        mso[d] = r / 256;
                        mq[d] = r % 256;
                    end
                    mleft[d] -= k;
                    if (mleft[d] == 0) mdone[d] = 1;
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (rst) for (int d = 0; d < 2; d++) begin
            check($sformatf("d%0d_q", d), int'(dq[d]), mq[d]);
            check($sformatf("d%0d_ser_out", d), int'(dso[d]), mso[d]);
            check($sformatf("d%0d_done", d), int'(ddone[d]), mdone[d]);
            check($sformatf("d%0d_busy", d), int'(dbusy[d]), int'(mleft[d] != 0));
            check($sformatf("d%0d_ready", d), int'(drdy[d]), int'(mleft[d] == 0));
        end
    end

    task automatic wait_idle();
        int i = 0;
        while (!(drdy[0] && drdy[1]) && i < 50) begin
            @(negedge clk);
            i++;
        end
        if (i >= 50) check("idle_timeout", 0, 1);
    endtask

    task automatic issue(input int o, input int a, input int dat, input int f);
        wait_idle();
        cmd_valid = 1; cmd_op = 3'(o); cmd_amt = 4'(a); load_data = 8'(dat); ser_in = 1'(f);
        @(negedge clk);
        cmd_valid = 0;
    endtask

    task automatic measure(output int a0, output int a1);
        a0 = -1; a1 = -1;
        for (int c = 1; c <= 20 && (a0 < 0 || a1 < 0); c++) begin
            @(negedge clk);
            if (ddone[0] && a0 < 0) a0 = c;
            if (ddone[1] && a1 < 0) a1 = c;
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1;
        @(negedge clk);
        check("ready_after_reset0", int'(drdy[0]), 1);
        check("ready_after_reset1", int'(drdy[1]), 1);
        // reset in the middle of a long shift
        issue(0, 0, 'h5A, 0);
        issue(1, 6, 0, 1);
        @(negedge clk);
        check("busy_mid_run", int'(dbusy[0]), 1);
        #1 rst = 0;
        #1;
        check("rst_q0", int'(dq[0]), 0);
        check("rst_q1", int'(dq[1]), 0);
        check("rst_busy0", int'(dbusy[0]), 0);
        check("rst_done0", int'(ddone[0]), 0);
        check("rst_ser_out0", int'(dso[0]), 0);
        @(negedge clk);
        #1 rst = 1;
        @(negedge clk);
        check("ready_after_release", int'(drdy[0]), 1);
        // SHL 3 with fill 1
        issue(0, 0, 'hA5, 0);
        issue(1, 3, 0, 1);
        measure(l0, l1);
        check("shl3_latency_s1", l0, 3);
        check("shl3_latency_s3", l1, 1);
        check("shl3_q0", int'(dq[0]), 'h2F);
        check("shl3_q1", int'(dq[1]), 'h2F);
        check("shl3_ser_out0", int'(dso[0]), 1);
        check("model_shl3", mq[0], 'h2F);
        // ASR keeps the sign, SHR clamps to a full flush
        issue(0, 0, 'h96, 0);
        issue(3, 2, 0, 0);
        measure(l0, l1);
        check("asr2_q0", int'(dq[0]), 'hE5);
        check("asr2_ser_out0", int'(dso[0]), 1);
        issue(2, 9, 0, 0);
        measure(l0, l1);
        check("shr9_latency_s1", l0, 8);
        check("shr9_latency_s3", l1, 3);
        check("shr9_q0", int'(dq[0]), 0);
        check("shr9_q1", int'(dq[1]), 0);
        // ROL 7 in 3/3/1 chunks on the STEP=3 engine
        issue(0, 0, 'h81, 0);
        issue(4, 7, 0, 0);
        measure(l0, l1);
        check("rol7_latency_s3", l1, 3);
        check("rol7_latency_s1", l0, 7);
        check("rol7_q1", int'(dq[1]), 'hC0);
        check("rol7_q0", int'(dq[0]), 'hC0);
        check("rol7_ser_out1", int'(dso[1]), 0);
        // ROR by WIDTH wraps to zero: immediate done, no RUN
        issue(0, 0, 'h3C, 0);
        issue(5, 8, 0, 0);
        check("ror8_done", int'(ddone[0]), 1);
        check("ror8_busy", int'(dbusy[0]), 0);
        check("ror8_q", int'(dq[0]), 'h3C);
        // back-to-back LOAD, NOP, CLEAR with valid held
        wait_idle();
        nd = 0;
        cmd_valid = 1; cmd_op = 0; cmd_amt = 0; load_data = 'h01;
        @(negedge clk);
        nd += int'(ddone[0]);
        check("b2b_load_q", int'(dq[0]), 'h01);
        cmd_op = 6;
        @(negedge clk);
        nd += int'(ddone[0]);
        cmd_op = 7;
        @(negedge clk);
        nd += int'(ddone[0]);
        cmd_valid = 0;
        check("b2b_done_count", nd, 3);
        check("b2b_q", int'(dq[0]), 0);
        // commands offered during RUN are dropped
        issue(0, 0, 'h96, 0);
        issue(2, 9, 0, 0);
        cmd_valid = 1; cmd_op = 0; load_data = 'hFF;
        repeat (5) @(negedge clk);
        cmd_valid = 0;
        wait_idle();
        check("ignore_q0", int'(dq[0]), 0);
        check("ignore_q1", int'(dq[1]), 'hFF);
        // random traffic with occasional async resets
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 99) == 0) begin
                #1 rst = 0;
                @(negedge clk);
                #1 rst = 1;
            end else begin
                cmd_valid = 1'($urandom_range(0, 1));
                cmd_op = 3'($urandom_range(0, 7));
                cmd_amt = 4'($urandom_range(0, 15));
                load_data = 8'($urandom);
                ser_in = 1'($urandom);
            end
        end
        cmd_valid = 0;
        wait_idle();
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
